// File: rtl/data_memory_arbiter_if.sv
// data_memory_arbiter_if: requester, memory and status signals of the data memory arbiter
// Ports: r0_*/r1_* requester handshakes, Mem*/Write_Data/Read_Data memory side, busy/gnt_id status.
// slave = arbiter view, master = requester/memory environment view.
interface data_memory_arbiter_if #(parameter int ADDR_W = 8, parameter int DATA_W = 32);
  logic              r0_req, r0_we, r0_ack;
  logic [ADDR_W-1:0] r0_addr;
  logic [DATA_W-1:0] r0_wdata, r0_rdata;
  logic              r1_req, r1_we, r1_ack;
  logic [ADDR_W-1:0] r1_addr;
  logic [DATA_W-1:0] r1_wdata, r1_rdata;
  logic [ADDR_W-1:0] MemAddr;
  logic [DATA_W-1:0] Write_Data, Read_Data;
  logic              MemRead, MemWrite, busy, gnt_id;
  modport slave (
    input  r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata, Read_Data,
    output r0_ack, r0_rdata, r1_ack, r1_rdata, MemAddr, Write_Data, MemRead, MemWrite, busy, gnt_id
  );
  modport master (
    output r0_req, r0_we, r0_addr, r0_wdata, r1_req, r1_we, r1_addr, r1_wdata, Read_Data,
    input  r0_ack, r0_rdata, r1_ack, r1_rdata, MemAddr, Write_Data, MemRead, MemWrite, busy, gnt_id
  );
endinterface

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin sharing of one Data_Memory between two req/ack requesters
// Ports: clk, reset (async, active-low), bus (slave modport: requester handshakes, memory drive, busy/gnt_id).
// All outputs come straight from registers; one transaction in flight at a time.
module data_memory_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic reset,
  data_memory_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic id, id_d, last, last_d, gnt, gnt_we;
  logic [ADDR_W-1:0] mem_addr, mem_addr_d;
  logic [DATA_W-1:0] write_data, write_data_d, rdata0, rdata0_d, rdata1, rdata1_d;
  logic mem_read, mem_read_d, mem_write, mem_write_d;
  logic ack0, ack0_d, ack1, ack1_d, busy, busy_d;
  // On a tie the requester not granted last time wins.
  assign gnt = (bus.r0_req && bus.r1_req) ? ~last : bus.r1_req;
  assign gnt_we = gnt ? bus.r1_we : bus.r0_we;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      id <= 1'b0;
      last <= 1'b1;
      mem_addr <= '0;
      write_data <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      rdata0 <= '0;
      rdata1 <= '0;
      busy <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      id <= id_d;
      last <= last_d;
      mem_addr <= mem_addr_d;
      write_data <= write_data_d;
      mem_read <= mem_read_d;
      mem_write <= mem_write_d;
      ack0 <= ack0_d;
      ack1 <= ack1_d;
      rdata0 <= rdata0_d;
      rdata1 <= rdata1_d;
      busy <= busy_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    id_d = id;
    last_d = last;
    mem_addr_d = mem_addr;
    write_data_d = write_data;
    mem_read_d = mem_read;
    mem_write_d = mem_write;
    ack0_d = 1'b0;
    ack1_d = 1'b0;
    rdata0_d = rdata0;
    rdata1_d = rdata1;
    case (state)
      IDLE: if (bus.r0_req || bus.r1_req) begin
        state_d = ISSUE;
        id_d = gnt;
        last_d = gnt;
        mem_addr_d = gnt ? bus.r1_addr : bus.r0_addr;
        write_data_d = gnt_we ? (gnt ? bus.r1_wdata : bus.r0_wdata) : write_data;
        mem_write_d = gnt_we;
        mem_read_d = ~gnt_we;
      end
      // mem_write being high identifies a write transaction in ISSUE.
      ISSUE: begin
        state_d = mem_write ? RESP : WAIT;
        cnt_d = 4'(RD_LAT - 1);
        mem_write_d = 1'b0;
        ack0_d = mem_write && !id;
        ack1_d = mem_write && id;
      end
      WAIT: if (cnt == 4'd0) begin
        state_d = RESP;
        mem_read_d = 1'b0;
        ack0_d = !id;
        ack1_d = id;
        rdata0_d = id ? rdata0 : bus.Read_Data;
        rdata1_d = id ? bus.Read_Data : rdata1;
      end else cnt_d = cnt - 4'd1;
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  assign bus.MemAddr = mem_addr;
  assign bus.Write_Data = write_data;
  assign bus.MemRead = mem_read;
  assign bus.MemWrite = mem_write;
  assign bus.r0_ack = ack0;
  assign bus.r1_ack = ack1;
  assign bus.r0_rdata = rdata0;
  assign bus.r1_rdata = rdata1;
  assign bus.busy = busy;
  assign bus.gnt_id = id;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed checks of the data memory arbiter (RD_LAT=1 and RD_LAT=3 builds)
module tb_data_memory_arbiter;
  localparam int AW = 8, DW = 32;
  logic clk = 1'b0, reset = 1'b0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  data_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  data_memory_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();
  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (.clk(clk), .reset(reset), .bus(bus));
  data_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (.clk(clk), .reset(reset), .bus(bus3));
  logic [DW-1:0] mem [256];
  always @(posedge clk) if (bus.MemWrite) mem[bus.MemAddr] <= bus.Write_Data;
  assign bus.Read_Data = mem[bus.MemAddr];
  logic [3:0] rd_n;
  always @(posedge clk or negedge reset)
    if (!reset) rd_n <= 4'd0;
    else rd_n <= bus3.MemRead ? rd_n + 4'd1 : 4'd0;
  assign bus3.Read_Data = 32'hA000_0000 + {28'd0, rd_n};
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    chk("mutex", 32'(bus.MemRead & bus.MemWrite), 0);
    chk("mutex3", 32'(bus3.MemRead & bus3.MemWrite), 0);
  endtask
  task automatic quiet(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_rd"}, 32'(bus.MemRead), 0);
    chk({tag, "_wr"}, 32'(bus.MemWrite), 0);
    chk({tag, "_ack0"}, 32'(bus.r0_ack), 0);
    chk({tag, "_ack1"}, 32'(bus.r1_ack), 0);
  endtask
  initial begin
    int n;
    {bus.r0_req, bus.r0_we, bus.r0_addr, bus.r0_wdata} = '0;
    {bus.r1_req, bus.r1_we, bus.r1_addr, bus.r1_wdata} = '0;
    {bus3.r0_req, bus3.r0_we, bus3.r0_addr, bus3.r0_wdata} = '0;
    {bus3.r1_req, bus3.r1_we, bus3.r1_addr, bus3.r1_wdata} = '0;
    #1;
    quiet("rst");
    chk("rst_addr", 32'(bus.MemAddr), 0);
    chk("rst_wdata", bus.Write_Data, 0);
    chk("rst_gnt", 32'(bus.gnt_id), 0);
    chk("rst_rdata0", bus.r0_rdata, 0);
    chk("rst_rdata1", bus.r1_rdata, 0);
    repeat (3) step;
    reset = 1'b1;
    repeat (4) begin
      step;
      quiet("idle");
    end
    bus.r0_we = 1'b1; bus.r0_addr = 8'h40; bus.r0_wdata = 32'hDEADBEEF; bus.r0_req = 1'b1;
    step;
    chk("w_memwrite", 32'(bus.MemWrite), 1);
    chk("w_addr", 32'(bus.MemAddr), 32'h40);
    chk("w_data", bus.Write_Data, 32'hDEADBEEF);
    chk("w_ack_early", 32'(bus.r0_ack), 0);
    chk("w_busy", 32'(bus.busy), 1);
    chk("w_gnt", 32'(bus.gnt_id), 0);
    step;
    chk("w_ack", 32'(bus.r0_ack), 1);
    chk("w_memwrite_drop", 32'(bus.MemWrite), 0);
    chk("w_ack1", 32'(bus.r1_ack), 0);
    bus.r0_req = 1'b0;
    step;
    quiet("w_done");
    bus.r1_we = 1'b0; bus.r1_addr = 8'h40; bus.r1_req = 1'b1;
    step;
    chk("r_rd1", 32'(bus.MemRead), 1);
    chk("r_addr", 32'(bus.MemAddr), 32'h40);
    chk("r_gnt", 32'(bus.gnt_id), 1);
    chk("r_ack_early1", 32'(bus.r1_ack), 0);
    step;
    chk("r_rd2", 32'(bus.MemRead), 1);
    chk("r_ack_early2", 32'(bus.r1_ack), 0);
    step;
    chk("r_ack", 32'(bus.r1_ack), 1);
    chk("r_rdata", bus.r1_rdata, 32'hDEADBEEF);
    chk("r_rd_drop", 32'(bus.MemRead), 0);
    chk("r_rdata0", bus.r0_rdata, 0);
    bus.r1_req = 1'b0;
    step;
    quiet("r_done");
    bus.r1_we = 1'b1; bus.r1_addr = 8'h80; bus.r1_wdata = 32'hCAFEF00D; bus.r1_req = 1'b1;
    step;
    chk("w80_memwrite", 32'(bus.MemWrite), 1);
    chk("w80_addr", 32'(bus.MemAddr), 32'h80);
    step;
    chk("w80_ack", 32'(bus.r1_ack), 1);
    chk("w80_rdata_hold", bus.r1_rdata, 32'hDEADBEEF);
    bus.r1_req = 1'b0;
    step;
    bus.r0_we = 1'b0; bus.r0_addr = 8'h40; bus.r0_req = 1'b1;
    step;
    step;
    chk("ab_wait_rd", 32'(bus.MemRead), 1);
    chk("ab_wait_busy", 32'(bus.busy), 1);
    reset = 1'b0;
    #1;
    quiet("ab_async");
    bus.r0_req = 1'b0;
    step;
    step;
    quiet("ab_held");
    chk("ab_rdata0", bus.r0_rdata, 0);
    reset = 1'b1;
    bus.r0_addr = 8'h80; bus.r0_req = 1'b1;
    step;
    chk("re_rd", 32'(bus.MemRead), 1);
    chk("re_addr", 32'(bus.MemAddr), 32'h80);
    step;
    chk("re_ack_early", 32'(bus.r0_ack), 0);
    step;
    chk("re_ack", 32'(bus.r0_ack), 1);
    chk("re_rdata", bus.r0_rdata, 32'hCAFEF00D);
    bus.r0_req = 1'b0;
    step;
    reset = 1'b0;
    step;
    reset = 1'b1;
    bus.r0_we = 1'b1; bus.r0_addr = 8'h10; bus.r0_wdata = 32'h11111111; bus.r0_req = 1'b1;
    bus.r1_we = 1'b1; bus.r1_addr = 8'h20; bus.r1_wdata = 32'h22222222; bus.r1_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      do begin
        step;
        n++;
      end while (!bus.r0_ack && !bus.r1_ack && n < 8);
      chk($sformatf("rr%0d_ack0", g), 32'(bus.r0_ack), 32'(g % 2 == 0));
      chk($sformatf("rr%0d_ack1", g), 32'(bus.r1_ack), 32'(g % 2 == 1));
      chk($sformatf("rr%0d_gnt", g), 32'(bus.gnt_id), 32'(g % 2));
    end
    bus.r0_req = 1'b0; bus.r1_req = 1'b0;
    step;
    step;
    quiet("rr_done");
    chk("rr_mem10", mem[8'h10], 32'h11111111);
    chk("rr_mem20", mem[8'h20], 32'h22222222);
    bus3.r0_we = 1'b0; bus3.r0_addr = 8'h05; bus3.r0_req = 1'b1;
    n = 0;
    do begin
      step;
      n++;
      if (n == 1) chk("l3_rd", 32'(bus3.MemRead), 1);
    end while (!bus3.r0_ack && n < 12);
    chk("l3_latency", 32'(n), 5);
    chk("l3_ack", 32'(bus3.r0_ack), 1);
    chk("l3_rdata", bus3.r0_rdata, 32'hA0000003);
    chk("l3_rd_drop", 32'(bus3.MemRead), 0);
    bus3.r0_req = 1'b0;
    step;
    chk("l3_ack_drop", 32'(bus3.r0_ack), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
